// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard scoreboard: one tracked pipeline entry
// and the bubble value that fills empty slots.
package hazard_pkg;

  // Widest register address the scoreboard can track; narrower ADDR_W values
  // are zero-extended into the entry's dst field.
  localparam int MAX_ADDR_W = 8;

  typedef struct packed {
    logic                  valid;
    logic                  wb_en;
    logic                  mem_read;
    logic [MAX_ADDR_W-1:0] dst;
  } entry_t;

  localparam entry_t BUBBLE = '0;

endpackage

// File: rtl/hazard_entry_match.sv
// Compares one tracked entry against the two ID-stage sources and reports a
// raw RAW match and whether that match is against an in-flight load.
module hazard_entry_match
  import hazard_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter bit IGNORE_R0 = 1'b0
) (
  input  entry_t            entry,
  input  logic [ADDR_W-1:0] src1,
  input  logic [ADDR_W-1:0] src2,
  input  logic              src1_qual,
  input  logic              src2_qual,
  output logic              match,
  output logic              load_match
);

  logic writer;
  logic hit1;
  logic hit2;

  assign writer = entry.valid && entry.wb_en;

  // Register 0 is hardwired on cores built with IGNORE_R0, so it never carries a dependency.
  assign hit1 = src1_qual && (entry.dst == MAX_ADDR_W'(src1)) && !(IGNORE_R0 && (src1 == '0));
  assign hit2 = src2_qual && (entry.dst == MAX_ADDR_W'(src2)) && !(IGNORE_R0 && (src2 == '0));

  assign match      = writer && (hit1 || hit2);
  assign load_match = match && entry.mem_read;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard detection: shadow pipeline of in-flight destinations, stall
// generation with optional load-use-only mode, branch flush and a stall counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int ADDR_W    = 5,
  parameter int DEPTH     = 2,   // tracked stages after ID, 1..4
  parameter int CNT_W     = 16,
  parameter bit IGNORE_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_src1,
  input  logic [ADDR_W-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic [ADDR_W-1:0] id_dst,
  input  logic              fwd_en,
  input  logic              flush,
  output logic              hazard,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [DEPTH-1:0] EXE_MASK = DEPTH'(1);

  entry_t           entries [DEPTH];
  logic [DEPTH-1:0] raw_match;
  logic [DEPTH-1:0] load_match;
  logic             push;

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    hazard_entry_match #(
      .ADDR_W    (ADDR_W),
      .IGNORE_R0 (IGNORE_R0)
    ) u_match (
      .entry      (entries[i]),
      .src1       (id_src1),
      .src2       (id_src2),
      .src1_qual  (id_valid),
      .src2_qual  (id_valid && id_two_src),
      .match      (raw_match[i]),
      .load_match (load_match[i])
    );
  end

  // With forwarding only a load still in EXE cannot be bypassed in time.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    hazard = 1'b0;
    if (id_valid && !flush) begin
      if (fwd_en) hazard = |(load_match & EXE_MASK);
      else        hazard = |raw_match;
    end
  end

  assign push = id_valid && !hazard && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the entries are a handful of flops rather than a RAM, so they take the async reset like any other state.
      for (int i = 0; i < DEPTH; i++) entries[i] <= BUBBLE;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= BUBBLE;
    end else begin
      // NOTE: non-blocking assignments let every stage read its neighbour's old value, which is what makes this a shift.
      for (int i = DEPTH - 1; i > 0; i--) entries[i] <= entries[i-1];
      if (push) entries[0] <= '{valid: 1'b1, wb_en: id_wb_en, mem_read: id_mem_read,
                                dst: MAX_ADDR_W'(id_dst)};
      else      entries[0] <= BUBBLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (hazard && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a vector table for single-cycle
// behaviour plus hand-written sequences for reset, saturation and r0 handling.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_src1;
  logic [4:0]  id_src2;
  logic        id_two_src;
  logic        id_wb_en;
  logic        id_mem_read;
  logic [4:0]  id_dst;
  logic        fwd_en;
  logic        flush;
  logic        hazard;
  logic [15:0] stall_cnt;
  logic        hazard_s;
  logic [2:0]  stall_cnt_s;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard dut (
    .clk (clk), .rst (rst), .id_valid (id_valid), .id_src1 (id_src1),
    .id_src2 (id_src2), .id_two_src (id_two_src), .id_wb_en (id_wb_en),
    .id_mem_read (id_mem_read), .id_dst (id_dst), .fwd_en (fwd_en),
    .flush (flush), .hazard (hazard), .stall_cnt (stall_cnt)
  );

  hazard_scoreboard #(.CNT_W (3), .IGNORE_R0 (1'b1)) dut_s (
    .clk (clk), .rst (rst), .id_valid (id_valid), .id_src1 (id_src1),
    .id_src2 (id_src2), .id_two_src (id_two_src), .id_wb_en (id_wb_en),
    .id_mem_read (id_mem_read), .id_dst (id_dst), .fwd_en (fwd_en),
    .flush (flush), .hazard (hazard_s), .stall_cnt (stall_cnt_s)
  );

  typedef struct {
    logic       valid;
    logic [4:0] src1;
    logic [4:0] src2;
    logic       two;
    logic       wb;
    logic       mr;
    logic [4:0] dst;
    logic       fwd;
    logic       fl;
    logic       exp_hz;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic two, input logic wb, input logic mr,
                       input logic [4:0] d, input logic fwd, input logic fl);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_wb_en = wb; id_mem_read = mr; id_dst = d; fwd_en = fwd; flush = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2;
    check({tag, "_rst_hazard"}, int'(hazard), 0);
    check({tag, "_rst_cnt"}, int'(stall_cnt), 0);
    check({tag, "_rst_cnt_s"}, int'(stall_cnt_s), 0);
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
  endtask

  initial begin
    int nhz;
    int exp_sat;
    //          valid src1 src2 two wb mr dst fwd fl  hz cnt
    vecs[0]  = '{1, 1, 2, 0, 1, 0, 3, 0, 0, 0, 0};  // push writer r3
    vecs[1]  = '{1, 3, 2, 0, 0, 0, 0, 0, 0, 1, 0};  // r3 in EXE
    vecs[2]  = '{1, 3, 2, 0, 0, 0, 0, 0, 0, 1, 1};  // r3 in MEM
    vecs[3]  = '{1, 3, 2, 0, 0, 0, 0, 0, 0, 0, 2};  // r3 retired
    vecs[4]  = '{1, 1, 2, 1, 1, 1, 7, 1, 0, 0, 2};  // push load r7
    vecs[5]  = '{1, 1, 7, 1, 0, 0, 0, 1, 0, 1, 2};  // load-use on src2
    vecs[6]  = '{1, 1, 7, 1, 0, 0, 0, 1, 0, 0, 3};  // load in MEM, forwarded
    vecs[7]  = '{1, 1, 2, 0, 1, 0, 7, 1, 0, 0, 3};  // push ALU writer r7
    vecs[8]  = '{1, 1, 7, 1, 0, 0, 0, 1, 0, 0, 3};  // ALU result forwarded
    vecs[9]  = '{1, 7, 2, 0, 0, 0, 0, 0, 0, 1, 3};  // forwarding off: r7 in MEM stalls
    vecs[10] = '{1, 7, 2, 0, 1, 0, 4, 0, 0, 0, 4};  // push writer r4
    vecs[11] = '{1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 4};  // src2 not read
    vecs[12] = '{1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 4};  // src2 read
    vecs[13] = '{1, 1, 2, 0, 1, 0, 5, 0, 0, 0, 5};  // push writer r5
    vecs[14] = '{1, 5, 2, 0, 1, 0, 6, 0, 1, 0, 5};  // flush masks hazard, drops push
    vecs[15] = '{1, 5, 6, 1, 1, 0, 9, 0, 0, 0, 5};  // all entries gone; push r9
    vecs[16] = '{0, 9, 2, 0, 0, 0, 0, 0, 0, 0, 5};  // id_valid=0 never stalls
    vecs[17] = '{1, 9, 2, 0, 0, 0, 0, 0, 0, 1, 5};  // r9 in MEM stalls

    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset("init");

    foreach (vecs[i]) begin
      drive(vecs[i].valid, vecs[i].src1, vecs[i].src2, vecs[i].two, vecs[i].wb,
            vecs[i].mr, vecs[i].dst, vecs[i].fwd, vecs[i].fl);
      #2;
      check($sformatf("vec%0d_hazard", i), int'(hazard), int'(vecs[i].exp_hz));
      check($sformatf("vec%0d_hazard_s", i), int'(hazard_s), int'(vecs[i].exp_hz));
      check($sformatf("vec%0d_cnt", i), int'(stall_cnt), vecs[i].exp_cnt);
      next_cycle();
    end

    // Reset asserted between edges in the middle of a two-cycle stall.
    do_reset("mid");
    drive(1, 1, 2, 0, 1, 0, 3, 0, 0);
    next_cycle();
    drive(1, 3, 2, 0, 0, 0, 0, 0, 0);
    #2;
    check("mid_stall1", int'(hazard), 1);
    next_cycle();
    #2;
    check("mid_stall2", int'(hazard), 1);
    check("mid_cnt_before", int'(stall_cnt), 1);
    rst = 1'b1;
    #1;
    check("mid_async_hazard", int'(hazard), 0);
    check("mid_async_cnt", int'(stall_cnt), 0);
    check("mid_async_hazard_s", int'(hazard_s), 0);
    #1;
    rst = 1'b0;
    next_cycle();
    #2;
    check("mid_after_rel", int'(hazard), 0);

    // Continuous dependency on r3 until ten stall cycles have been seen.
    do_reset("sat");
    drive(1, 3, 2, 0, 1, 0, 3, 0, 0);
    nhz = 0;
    for (int c = 0; c < 60 && nhz < 10; c++) begin
      #2;
      if (hazard_s) nhz++;
      next_cycle();
    end
    exp_sat = (nhz > 7) ? 7 : nhz;
    check("sat_stalls_seen", nhz, 10);
    check("sat_cnt_w3", int'(stall_cnt_s), exp_sat);
    check("sat_cnt_w16", int'(stall_cnt), nhz);

    // Writer to r0 followed by a read of r0.
    do_reset("r0");
    drive(1, 1, 2, 0, 1, 0, 0, 0, 0);
    next_cycle();
    drive(1, 0, 2, 0, 0, 0, 0, 0, 0);
    #2;
    check("r0_ignored", int'(hazard_s), 0);
    check("r0_tracked", int'(hazard), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
